// File: rtl/pll_video_ctrl.sv
// pll_video_ctrl: ECP5 EHXPLLL reset/lock supervisor and dynamic phase-step sequencer.
// Define PLL_VIDEO_CTRL_STATUS_EN to implement relock_count/timeout_count.
`timescale 1ns/1ps
module pll_video_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int PH_SETUP     = 4,
    parameter int PH_PULSE     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic [1:0] pll_phasesel,
    output logic       pll_phasedir,
    output logic       pll_phasestep,
    output logic       pll_phaseloadreg,
    output logic       video_reset_n,
    output logic       ready,
    input  logic       ph_req,
    input  logic [1:0] ph_sel,
    input  logic       ph_dir,
    output logic       ph_ack,
    output logic [7:0] relock_count,
    output logic [7:0] timeout_count
);
    localparam int CW = $clog2(RST_CYCLES + LOCK_STABLE + LOCK_TIMEOUT
                               + 2 * (PH_SETUP + PH_PULSE));

    typedef enum logic [3:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_PH_SETUP,
        S_PH_STEP,
        S_PH_HOLD,
        S_PH_LOAD,
        S_PH_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_s1_q, lock_s_q;
    logic          pll_rst_q, pll_rst_d;
    logic [1:0]    sel_q, sel_d;
    logic          dir_q, dir_d;
    logic          step_q, step_d;
    logic          load_q, load_d;
    logic          vrst_n_q, vrst_n_d;
    logic          ready_q, ready_d;
    logic          ack_q, ack_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        sel_d   = sel_q;
        dir_d   = dir_q;
        unique case (state_q)
            S_RESET_PLL: if (cnt_q == CW'(RST_CYCLES - 1)) begin
                state_d = S_WAIT_LOCK;
                cnt_d   = '0;
            end
            S_WAIT_LOCK: if (lock_s_q) begin
                // the sample that ends the wait is the first stable cycle
                state_d = S_STABLE;
                cnt_d   = CW'(1);
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
            S_STABLE: if (!lock_s_q) begin
                state_d = S_WAIT_LOCK;
                cnt_d   = '0;
            end else if (cnt_q >= CW'(LOCK_STABLE - 1)) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: if (!lock_s_q) begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end else if (ph_req) begin
                state_d = S_PH_SETUP;
                cnt_d   = '0;
                sel_d   = ph_sel;
                dir_d   = ph_dir;
            end
            S_PH_SETUP: if (cnt_q == CW'(PH_SETUP - 1)) begin
                state_d = S_PH_STEP;
                cnt_d   = '0;
            end
            S_PH_STEP: if (cnt_q == CW'(PH_PULSE - 1)) begin
                state_d = S_PH_HOLD;
                cnt_d   = '0;
            end
            S_PH_HOLD: if (cnt_q == CW'(PH_SETUP - 1)) begin
                state_d = S_PH_LOAD;
                cnt_d   = '0;
            end
            S_PH_LOAD: if (cnt_q == CW'(PH_PULSE - 1)) begin
                state_d = S_PH_DONE;
                cnt_d   = '0;
            end
            S_PH_DONE: if (!ph_req) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase
        if (!lock_s_q && state_q inside {S_PH_SETUP, S_PH_STEP, S_PH_HOLD,
                                         S_PH_LOAD, S_PH_DONE}) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
        end
        // outputs decode the next state so they register with it
        pll_rst_d = (state_d == S_RESET_PLL);
        step_d    = (state_d != S_PH_STEP);
        load_d    = (state_d != S_PH_LOAD);
        ack_d     = (state_d == S_PH_DONE);
        ready_d   = (state_d == S_RUN);
        vrst_n_d  = (state_d inside {S_RUN, S_PH_SETUP, S_PH_STEP, S_PH_HOLD,
                                     S_PH_LOAD, S_PH_DONE});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_s1_q <= 1'b0;
            lock_s_q  <= 1'b0;
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            sel_q     <= 2'd0;
            dir_q     <= 1'b0;
            step_q    <= 1'b1;
            load_q    <= 1'b1;
            vrst_n_q  <= 1'b0;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            lock_s1_q <= pll_locked;
            lock_s_q  <= lock_s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            load_q    <= load_d;
            vrst_n_q  <= vrst_n_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
        end
    end

    assign pll_rst          = pll_rst_q;
    assign pll_phasesel     = sel_q;
    assign pll_phasedir     = dir_q;
    assign pll_phasestep    = step_q;
    assign pll_phaseloadreg = load_q;
    assign video_reset_n    = vrst_n_q;
    assign ready            = ready_q;
    assign ph_ack           = ack_q;

`ifdef PLL_VIDEO_CTRL_STATUS_EN
    logic [7:0] relock_q, relock_d;
    logic [7:0] timeout_q, timeout_d;
    logic       lost_ev, tmo_ev;

    always_comb begin
        lost_ev   = (state_d == S_RESET_PLL)
                    && (state_q inside {S_RUN, S_PH_SETUP, S_PH_STEP,
                                        S_PH_HOLD, S_PH_LOAD, S_PH_DONE});
        tmo_ev    = (state_q == S_WAIT_LOCK) && (state_d == S_RESET_PLL);
        relock_d  = relock_q;
        timeout_d = timeout_q;
        if (lost_ev && relock_q != 8'hff)
            relock_d = relock_q + 8'd1;
        if (tmo_ev && timeout_q != 8'hff)
            timeout_d = timeout_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            relock_q  <= 8'd0;
            timeout_q <= 8'd0;
        end else begin
            relock_q  <= relock_d;
            timeout_q <= timeout_d;
        end
    end

    assign relock_count  = relock_q;
    assign timeout_count = timeout_q;
`else
    assign relock_count  = 8'd0;
    assign timeout_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_video_ctrl.sv
// tb_pll_video_ctrl: directed and randomized bench for pll_video_ctrl
// against a cycle-level behavioural model of the supervisor.
`timescale 1ns/1ps
module tb_pll_video_ctrl;
    localparam int RST_C  = 4;
    localparam int LSTAB  = 8;
    localparam int LTMO   = 32;
    localparam int PHS    = 2;
    localparam int PHP    = 2;
    localparam int PH_END = 2 * PHS + 2 * PHP;
`ifdef PLL_VIDEO_CTRL_STATUS_EN
    localparam bit ST_EN = 1'b1;
`else
    localparam bit ST_EN = 1'b0;
`endif
    localparam logic [31:0] RST_VEC = {7'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1,
                                       1'b0, 1'b0, 1'b0, 8'd0, 8'd0};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       ph_req = 1'b0;
    logic [1:0] ph_sel = 2'd0;
    logic       ph_dir = 1'b0;
    logic       pll_rst, pll_phasedir, pll_phasestep, pll_phaseloadreg;
    logic [1:0] pll_phasesel;
    logic       video_reset_n, ready, ph_ack;
    logic [7:0] relock_count, timeout_count;

    int n_chk = 0;
    int n_pass = 0;

    pll_video_ctrl #(
        .RST_CYCLES  (RST_C),
        .LOCK_STABLE (LSTAB),
        .LOCK_TIMEOUT(LTMO),
        .PH_SETUP    (PHS),
        .PH_PULSE    (PHP)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .pll_phasesel    (pll_phasesel),
        .pll_phasedir    (pll_phasedir),
        .pll_phasestep   (pll_phasestep),
        .pll_phaseloadreg(pll_phaseloadreg),
        .video_reset_n   (video_reset_n),
        .ready           (ready),
        .ph_req          (ph_req),
        .ph_sel          (ph_sel),
        .ph_dir          (ph_dir),
        .ph_ack          (ph_ack),
        .relock_count    (relock_count),
        .timeout_count   (timeout_count)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // behavioural model: mode plus cycles spent in it
    typedef enum {M_RST, M_WAIT, M_STAB, M_RUN, M_PH} mode_t;
    mode_t      m_mode;
    int         m_t, m_relock, m_tmo;
    bit         m_s1, m_s2, m_dir;
    logic [1:0] m_sel;

    task automatic m_init();
        m_mode = M_RST; m_t = 0; m_relock = 0; m_tmo = 0;
        m_s1 = 0; m_s2 = 0; m_dir = 0; m_sel = 2'd0;
    endtask

    task automatic m_go(input mode_t m);
        m_mode = m;
        m_t = 0;
    endtask

    task automatic m_lost();
        m_go(M_RST);
        m_relock = (m_relock < 255) ? m_relock + 1 : 255;
    endtask

    task automatic m_step();
        bit ls;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        m_t++;
        case (m_mode)
            M_RST:  if (m_t == RST_C) m_go(M_WAIT);
            M_WAIT: if (ls) begin
                m_go(M_STAB);
                m_t = 1;
            end else if (m_t == LTMO) begin
                m_go(M_RST);
                m_tmo = (m_tmo < 255) ? m_tmo + 1 : 255;
            end
            M_STAB: if (!ls) m_go(M_WAIT);
                    else if (m_t == LSTAB) m_go(M_RUN);
            M_RUN:  if (!ls) m_lost();
                    else if (ph_req) begin
                        m_go(M_PH);
                        m_sel = ph_sel;
                        m_dir = ph_dir;
                    end
            M_PH:   if (!ls) m_lost();
                    else if (m_t > PH_END && !ph_req) m_go(M_RUN);
            default: ;
        endcase
    endtask

    function automatic logic [31:0] m_out();
        logic ph, st, ld, ak;
        logic [7:0] rc, tc;
        ph = (m_mode == M_PH);
        st = !(ph && m_t >= PHS && m_t < PHS + PHP);
        ld = !(ph && m_t >= 2 * PHS + PHP && m_t < PH_END);
        ak = ph && m_t >= PH_END;
        rc = ST_EN ? 8'(m_relock) : 8'd0;
        tc = ST_EN ? 8'(m_tmo) : 8'd0;
        return {7'd0, m_mode == M_RST, m_sel, m_dir, st, ld,
                ph || m_mode == M_RUN, m_mode == M_RUN, ak, rc, tc};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {7'd0, pll_rst, pll_phasesel, pll_phasedir, pll_phasestep,
                pll_phaseloadreg, video_reset_n, ready, ph_ack,
                relock_count, timeout_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        check("cyc", dut_vec(), m_out());
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin tick(); n++; end while (!ready && n < 60);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n, fall, prev, lo_left;
        int rises[$];
        int t_step, t_load, t_ack, nls, nll;
        bit seen, vrn_seen;

        m_init();
        repeat (3) @(negedge clk);
        check("reset", dut_vec(), RST_VEC);
        reset_n = 1'b1;

        fall = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (!pll_rst && fall < 0) fall = i;
        end
        check("rst_fall", fall, RST_C);
        pll_locked = 1'b1;
        wait_ready(n);
        check("cold_ready", n, LSTAB + 2);
        check("cold_cnt", {relock_count, timeout_count}, 0);

        pll_locked = 1'b0;
        prev = 0;
        vrn_seen = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (pll_rst && prev == 0) rises.push_back(i);
            prev = pll_rst;
            if (i > 3 && video_reset_n) vrn_seen = 1;
        end
        check("tmo_rises", rises.size(), 3);
        if (rises.size() >= 3) begin
            check("tmo_period1", rises[1] - rises[0], RST_C + LTMO);
            check("tmo_period2", rises[2] - rises[1], RST_C + LTMO);
        end
        check("tmo_vrn", vrn_seen, 0);
        check("tmo_count", timeout_count, ST_EN ? 2 : 0);
        check("tmo_relock", relock_count, ST_EN ? 1 : 0);

        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_ready(n);
        check("glitch_ready", n, LSTAB + 2);

        ph_sel = 2'd2; ph_dir = 1'b1; ph_req = 1'b1;
        t_step = -1; t_load = -1; t_ack = -1; nls = 0; nll = 0;
        for (int i = 1; i <= 20 && t_ack < 0; i++) begin
            tick();
            if (!pll_phasestep) begin nls++; if (t_step < 0) t_step = i; end
            if (!pll_phaseloadreg) begin nll++; if (t_load < 0) t_load = i; end
            if (ph_ack) t_ack = i;
        end
        check("ph_ack_lat", t_ack, PH_END + 1);
        check("ph_step_at", t_step, PHS + 1);
        check("ph_step_w", nls, PHP);
        check("ph_load_at", t_load, 2 * PHS + PHP + 1);
        check("ph_load_w", nll, PHP);
        check("ph_sel", pll_phasesel, 2);
        check("ph_dir", pll_phasedir, 1);
        tick();
        check("ph_ack_hold", ph_ack, 1);
        ph_req = 1'b0;
        tick();
        check("ph_ack_clr", ph_ack, 0);
        check("ph_ready", ready, 1);

        ph_sel = 2'd1; ph_dir = 1'b0; ph_req = 1'b1;
        tick();
        pll_locked = 1'b0;
        seen = 0; nls = 0;
        repeat (3) begin
            tick();
            if (!pll_phasestep) nls++;
            if (ph_ack) seen = 1;
        end
        check("abort_step_seen", nls > 0, 1);
        check("abort_step", pll_phasestep, 1);
        check("abort_rst", pll_rst, 1);
        repeat (6) begin tick(); if (ph_ack) seen = 1; end
        check("abort_no_ack", seen, 0);
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ph_ack && n < 60);
        check("relock_ack", ph_ack, 1);
        check("relock_sel", pll_phasesel, 1);
        check("relock_cnt", relock_count, ST_EN ? 2 : 0);
        ph_req = 1'b0;
        tick();

        for (int e = 0; e < 260; e++) begin
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            n = 0;
            do begin tick(); n++; end while (ready && n < 10);
            wait_ready(n);
            check("sat_wait", ready, 1);
        end
        check("sat_relock", relock_count, ST_EN ? 255 : 0);
        check("sat_tmo", timeout_count, ST_EN ? 2 : 0);

        lo_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (lo_left > 0) begin
                lo_left--;
                pll_locked = (lo_left == 0);
            end else if ($urandom_range(0, 149) == 0) begin
                pll_locked = 1'b0;
                lo_left = $urandom_range(1, 50);
            end
            if (!ph_req && !ph_ack && $urandom_range(0, 3) == 0) begin
                ph_req = 1'b1;
                ph_sel = 2'($urandom);
                ph_dir = 1'($urandom);
            end else if (ph_req && ph_ack && $urandom_range(0, 2) == 0) begin
                ph_req = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
